// File: rtl/argmax_chunk_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : argmax_chunk_sequencer_if
// Description : Bundle of control, result and buffer-read signals for
//               argmax_chunk_sequencer.
//                 start/length          : request (environment -> sequencer)
//                 busy/done/max/argmax  : status and result
//                 rd_en/rd_addr/rd_data : 16-lane chunk buffer read port
//               The "slave" modport is taken by the sequencer. The "master"
//               modport is taken by the environment, which is the requester
//               plus the buffer.
// Revision    : 1.0 - initial release
// ============================================================================
interface argmax_chunk_sequencer_if #(
  parameter int WIDTH        = 8,
  parameter int ARGMAX_WIDTH = 8
);
  logic                        start;
  logic [ARGMAX_WIDTH:0]       length;
  logic                        busy;
  logic                        rd_en;
  logic [ARGMAX_WIDTH-5:0]     rd_addr;
  logic [16*WIDTH-1:0]         rd_data;
  logic                        done;
  logic signed [WIDTH-1:0]     max;
  logic [ARGMAX_WIDTH-1:0]     argmax;

  modport master (
    output start, length, rd_data,
    input  busy, rd_en, rd_addr, done, max, argmax
  );

  modport slave (
    input  start, length, rd_data,
    output busy, rd_en, rd_addr, done, max, argmax
  );
endinterface
`default_nettype wire

// File: rtl/argmax_chunk_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : argmax_chunk_sequencer
// Description : Computes the signed max/argmax of a vector of up to
//               2^ARGMAX_WIDTH elements. The vector is read one 16-lane chunk
//               at a time (FETCH, then ACC). Each chunk is reduced with a
//               4-level compare tree, and the chunk result is folded into a
//               running result.
// Ports       : clk, rst - clock, synchronous active-high reset
//               bus      - argmax_chunk_sequencer_if.slave
//                          (start/length in, busy/done/max/argmax out,
//                           rd_en/rd_addr out, rd_data in one cycle later)
// Revision    : 1.0 - initial release
// ============================================================================
module argmax_chunk_sequencer #(
  parameter int WIDTH        = 8,
  parameter int ARGMAX_WIDTH = 8
) (
  input  wire logic               clk,
  input  wire logic               rst,
  argmax_chunk_sequencer_if.slave bus
);

  localparam int CW = ARGMAX_WIDTH - 4;
  localparam logic [ARGMAX_WIDTH:0]   LEN_MAX    = {1'b1, {ARGMAX_WIDTH{1'b0}}};
  localparam logic [ARGMAX_WIDTH:0]   CHUNK_STEP = {{(ARGMAX_WIDTH-4){1'b0}}, 5'd16};
  localparam logic signed [WIDTH-1:0] VAL_MIN    = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ACC   = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] val;
    logic [3:0]       lane;
  } cand_t;

  state_t                  state, state_nxt;
  logic [ARGMAX_WIDTH:0]   len_q;
  logic [CW-1:0]           chunk;
  logic signed [WIDTH-1:0] max_q;
  logic [ARGMAX_WIDTH-1:0] argmax_q;

  logic [ARGMAX_WIDTH:0]   len_clamped;
  logic                    is_last;
  cand_t                   l0 [16];
  cand_t                   l1 [8];
  cand_t                   l2 [4];
  cand_t                   l3 [2];
  cand_t                   best;

  // The right candidate always covers the higher lane indices. It wins only
  // when it is strictly greater, so ties resolve to the lowest lane.
  function automatic cand_t pick(input cand_t left, input cand_t right);
    return ($signed(right.val) > $signed(left.val)) ? right : left;
  endfunction

  assign len_clamped = (bus.length > LEN_MAX) ? LEN_MAX : bus.length;

  // The chunk is the last one when its end, (chunk+1)*16, reaches L.
  assign is_last = ({1'b0, chunk, 4'b0000} + CHUNK_STEP) >= len_q;

  // Lane masking and the 16-input compare tree.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      l0[i].val  = ({1'b0, chunk, 4'(i)} < len_q) ? bus.rd_data[i*WIDTH +: WIDTH]
                                                  : VAL_MIN;
      l0[i].lane = 4'(i);
    end
    for (int i = 0; i < 8; i++) l1[i] = pick(l0[2*i], l0[2*i+1]);
    for (int i = 0; i < 4; i++) l2[i] = pick(l1[2*i], l1[2*i+1]);
    for (int i = 0; i < 2; i++) l3[i] = pick(l2[2*i], l2[2*i+1]);
    best = pick(l3[0], l3[1]);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    bus.busy    = 1'b0;
    bus.rd_en   = 1'b0;
    bus.done    = 1'b0;
    bus.rd_addr = chunk;
    bus.max     = max_q;
    bus.argmax  = argmax_q;
    case (state)
      IDLE: begin
        if (bus.start) state_nxt = (len_clamped == '0) ? DONE : FETCH;
      end
      FETCH: begin
        bus.busy  = 1'b1;
        bus.rd_en = 1'b1;
        state_nxt = ACC;
      end
      ACC: begin
        bus.busy  = 1'b1;
        state_nxt = is_last ? DONE : FETCH;
      end
      DONE: begin
        bus.busy  = 1'b1;
        bus.done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Length latch, chunk counter and the running result.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q    <= '0;
      chunk    <= '0;
      max_q    <= '0;
      argmax_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            len_q <= len_clamped;
            chunk <= '0;
            if (len_clamped == '0) begin
              max_q    <= VAL_MIN;
              argmax_q <= '0;
            end
          end
        end
        ACC: begin
          // Chunk 0 seeds the result. Later chunks replace it only when they
          // are strictly larger, which keeps the earliest index on equal values.
          if (chunk == '0 || $signed(best.val) > max_q) begin
            max_q    <= best.val;
            argmax_q <= {chunk, best.lane};
          end
          if (!is_last) chunk <= chunk + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_argmax_chunk_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_argmax_chunk_sequencer
// Description : Self-checking bench for argmax_chunk_sequencer. A 256-entry
//               element memory serves the chunk reads. Expected results come
//               from a flat scan over the first L elements.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_argmax_chunk_sequencer;

  localparam int W  = 8;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  argmax_chunk_sequencer_if #(.WIDTH(W), .ARGMAX_WIDTH(AW)) bus ();

  argmax_chunk_sequencer #(.WIDTH(W), .ARGMAX_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic signed [W-1:0] mem [0:255];
  int checks = 0;
  int errors = 0;

  function automatic logic [16*W-1:0] pack_chunk(input logic [3:0] a);
    logic [16*W-1:0] r;
    for (int i = 0; i < 16; i++) r[i*W +: W] = mem[int'(a)*16 + i];
    return r;
  endfunction

  // Buffer with one-cycle read latency.
  always @(posedge clk) begin
    if (bus.rd_en === 1'b1) bus.rd_data <= pack_chunk(bus.rd_addr);
  end

  // Reference: the first occurrence of the largest value among elements 0..L-1.
  function automatic void ref_model(input int L, output int mx, output int am);
    mx = -128;
    am = 0;
    for (int k = 0; k < L; k++) begin
      if (k == 0 || int'(mem[k]) > mx) begin
        mx = int'(mem[k]);
        am = k;
      end
    end
  endfunction

  task automatic fill_random();
    for (int k = 0; k < 256; k++) mem[k] = W'($urandom);
  endtask

  // One reduction. The task checks the done cycle, the fetch sequence, busy,
  // the result, and that the result holds afterwards. When poke is set, start
  // pulses with a random length are driven while the sequencer is busy.
  task automatic run(input int len, input bit poke, input string name);
    int  L, C, exp_done, mx, am, done_cyc, nfetch, got_max;
    bit  busy_ok, fetch_ok, hold_ok;
    L        = (len > 256) ? 256 : len;
    C        = (L + 15) / 16;
    exp_done = (L == 0) ? 1 : 2*C + 1;
    ref_model(L, mx, am);

    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_before: busy=%b required 0", name, bus.busy);
    end
    bus.start  = 1'b1;
    bus.length = len[AW:0];
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    bus.length = (AW+1)'($urandom);

    done_cyc = -1;
    nfetch   = 0;
    busy_ok  = 1'b1;
    fetch_ok = 1'b1;
    for (int cyc = 1; cyc <= 40 && done_cyc < 0; cyc++) begin
      @(negedge clk);
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if (bus.rd_en === 1'b1) begin
        if (bus.rd_addr !== nfetch[3:0] || cyc != 1 + 2*nfetch) fetch_ok = 1'b0;
        nfetch++;
      end else if (bus.rd_en !== 1'b0) begin
        fetch_ok = 1'b0;
      end
      if (bus.done === 1'b1) begin
        done_cyc  = cyc;
        bus.start = 1'b0;
      end else if (poke) begin
        bus.start  = cyc[0];
        bus.length = (AW+1)'($urandom);
      end
    end
    bus.start = 1'b0;

    checks++;
    if (done_cyc != exp_done) begin
      errors++;
      $display("FAIL %s done_cycle: got %0d required %0d", name, done_cyc, exp_done);
    end
    checks++;
    if (!busy_ok) begin
      errors++;
      $display("FAIL %s busy: busy dropped before done (got 0 required 1)", name);
    end
    checks++;
    if (!fetch_ok || nfetch != C) begin
      errors++;
      $display("FAIL %s fetch_seq: fetches=%0d ordered=%b required %0d ordered", name, nfetch, fetch_ok, C);
    end
    got_max = bus.max;
    checks++;
    if (got_max !== mx) begin
      errors++;
      $display("FAIL %s max: got %0d required %0d", name, got_max, mx);
    end
    checks++;
    if (bus.argmax !== am[AW-1:0]) begin
      errors++;
      $display("FAIL %s argmax: got %0d required %0d", name, bus.argmax, am);
    end

    hold_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      got_max = bus.max;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || got_max !== mx || bus.argmax !== am[AW-1:0])
        hold_ok = 1'b0;
    end
    checks++;
    if (!hold_ok) begin
      errors++;
      $display("FAIL %s hold: done=%b busy=%b max=%0d argmax=%0d required 0 0 %0d %0d",
               name, bus.done, bus.busy, got_max, bus.argmax, mx, am);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    checks++;
    if (bus.busy !== 1'b0 || bus.rd_en !== 1'b0 || bus.done !== 1'b0 ||
        bus.rd_addr !== '0 || bus.max !== '0 || bus.argmax !== '0) begin
      errors++;
      $display("FAIL %s: busy=%b rd_en=%b done=%b rd_addr=%0d max=%0d argmax=%0d required all 0",
               name, bus.busy, bus.rd_en, bus.done, bus.rd_addr, bus.max, bus.argmax);
    end
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.length = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
  endtask

  task automatic test_directed();
    fill_random();
    for (int k = 0; k < 16; k++) mem[k] = W'(k);
    mem[9] = 8'sd100;
    run(16, 1'b0, "single_chunk");

    fill_random();
    for (int k = 0; k < 48; k++) mem[k] = -8'sd5;
    mem[39] = 8'sd3;
    mem[41] = 8'sd127;
    run(40, 1'b0, "masked_tail");

    fill_random();
    for (int k = 0; k < 48; k++) mem[k] = -8'sd1;
    mem[5] = 8'sd20; mem[21] = 8'sd20; mem[37] = 8'sd20;
    run(48, 1'b0, "tie_across_chunks");

    fill_random();
    for (int k = 0; k < 16; k++) mem[k] = 8'sd0;
    mem[3] = 8'sd50; mem[4] = 8'sd50;
    run(16, 1'b0, "tie_in_chunk");

    for (int k = 0; k < 256; k++) mem[k] = -8'sd128;
    run(256, 1'b0, "all_min_full");

    fill_random();
    run(0, 1'b0, "zero_length");
    run(300, 1'b0, "clamp_300");
    run(511, 1'b0, "clamp_511");
  endtask

  task automatic test_boundaries();
    int lens [6] = '{1, 15, 17, 255, 256, 257};
    foreach (lens[i]) begin
      fill_random();
      run(lens[i], 1'b0, $sformatf("len_%0d", lens[i]));
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++) begin
      fill_random();
      run($urandom_range(0, 300), 1'b0, $sformatf("rand_%0d", n));
    end
  endtask

  task automatic test_start_while_busy();
    for (int n = 0; n < 4; n++) begin
      fill_random();
      run($urandom_range(1, 256), 1'b1, $sformatf("busy_start_%0d", n));
    end
  endtask

  task automatic test_mid_reset();
    fill_random();
    @(negedge clk);
    bus.start  = 1'b1;
    bus.length = 9'd256;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1 || bus.rd_en !== 1'b0 || bus.rd_addr !== 4'd2) begin
      errors++;
      $display("FAIL mid_reset_acc2: busy=%b rd_en=%b rd_addr=%0d required 1 0 2",
               bus.busy, bus.rd_en, bus.rd_addr);
    end
    rst = 1'b1;
    @(negedge clk);
    check_outputs_zero("mid_reset");
    rst = 1'b0;
    fill_random();
    run(70, 1'b0, "after_reset");
  endtask

  initial begin
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.length = '0;
    test_reset();
    test_directed();
    test_boundaries();
    test_random();
    test_start_while_busy();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/argmax_chunk_sequencer.md
# argmax_chunk_sequencer

Controller that computes the signed max and argmax of a vector of up to 2^ARGMAX_WIDTH elements held in a 16-lane-wide buffer. It fetches the vector one 16-element chunk at a time and reduces each chunk with a 16-input parallel signed compare tree. It folds each chunk result into a running max/argmax and signals completion with a start/done handshake. It sits between the activation buffer and the classifier output stage, and replaces free-running serial argmax accumulation with explicit length-bounded sequencing.

## Interface
Parameters:
- WIDTH, 8, signed element width.
- ARGMAX_WIDTH, 8, argmax index width; must be ≥ 5. Chunk address width is ARGMAX_WIDTH-4.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a new reduction; sampled only in IDLE.
- length  input  ARGMAX_WIDTH+1  element count, latched on accepted start.
- busy  output  1  high in every state except IDLE.
- rd_en  output  1  buffer read strobe.
- rd_addr  output  ARGMAX_WIDTH-4  chunk index.
- rd_data  input  16*WIDTH  chunk data, valid the cycle after rd_en; lane i at bits [i*WIDTH +: WIDTH].
- done  output  1  one-cycle completion pulse.
- max  output  WIDTH (signed)  result maximum, held until the next accepted start.
- argmax  output  ARGMAX_WIDTH  result index, held until the next accepted start.

## Operation
- States: IDLE, FETCH, ACC, DONE.
- IDLE:
  - On start=1, latch length as L and clear the chunk counter.
  - Values of L above 2^ARGMAX_WIDTH clamp to 2^ARGMAX_WIDTH.
  - If L=0, go to DONE with max=-2^(WIDTH-1) and argmax=0.
  - Otherwise go to FETCH.
- FETCH: rd_en=1 and rd_addr=chunk; then go to ACC.
- ACC: rd_data is valid in this cycle.
  - Lane i is valid iff chunk*16+i < L. Invalid lanes are replaced by -2^(WIDTH-1) before comparison.
  - The 16-lane tree picks the lane with the largest signed value. On a tie, the lowest lane index wins.
  - On chunk 0, the running max/argmax load unconditionally; argmax = lane.
  - On later chunks, they update only if the chunk max is strictly greater than the running max. The new argmax is {chunk, lane[3:0]}. Equal values keep the earlier index.
  - If this is the last chunk (chunk == ceil(L/16)-1), go to DONE. Otherwise increment chunk and go to FETCH.
- DONE: done=1 for exactly one cycle, then return to IDLE.
- max and argmax change only in ACC and in the L=0 path. They are stable whenever done=1 and afterwards.
- start asserted while busy=1 is ignored. It is not queued.
- length is ignored except on an accepted start.
- Reset values, also applied on rst mid-operation: state IDLE; busy, rd_en, done = 0; rd_addr, chunk = 0; max, argmax = 0. No partial result survives a reset.

## Timing
- Let C = ceil(L/16). start is accepted in cycle 0.
- FETCH for chunk k occurs in cycle 1+2k, and ACC in cycle 2+2k.
- done is high in cycle 2C+1. For L=0, done is high in cycle 1.
- busy is high from cycle 1 through the DONE cycle inclusive.
- The earliest next accepted start is the cycle after DONE, i.e. the first IDLE cycle.
- Buffer read latency is fixed at one cycle; there is no backpressure.
- Comparison is purely combinational within ACC; one chunk completes per 2 cycles.
- Maximum latency for L=256 is 33 cycles.

## Test plan
- Length 16, rd_data lanes = {0,1,…,15} except lane 9 = 100 → single FETCH/ACC; done in cycle 3; max=100, argmax=9.
- Length 40, chunks 0–2 of all -5, chunk 2 lane 7 = 3, chunk 2 lane 9 (index 41) = 127 → lane 9 is masked; done in cycle 7; max=3, argmax=39.
- Ties: length 48, value 20 at indices 5, 21, 37, all others -1 → argmax=5, max=20. Also within a chunk, lanes 3 and 4 both 50 → argmax picks lane 3.
- All elements -128, length 256 → max=-128, argmax=0; done in cycle 33; rd_addr sequence 0..15.
- length=0 → done in cycle 1, max=-128, argmax=0, rd_en never asserted. length=300 clamps to 256.
- rst asserted in the ACC of chunk 2 → next cycle IDLE, all outputs 0. start pulses during busy are ignored: no extra done, result unchanged.
